ram_stream_reader: RTL and testbench

//  Read-side master for the 4096x64 dual-port RAM. Accepts a burst command (start address, length),

---
 rtl/ram_stream_reader.sv | 171 +++++++++++++++++
 tb/tb_ram_stream_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
`default_nettype none
// =============================================================================
// ram_stream_reader : burst read master streaming RAM words over valid/ready
// Revision: 1.0
// =============================================================================
module ram_stream_reader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_rd_add,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 2;
  localparam int LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              ram_rd_q, ram_rd_d;
  logic [ADDR_W-1:0] ram_rd_add_q, ram_rd_add_d;
  logic              rd_last_q, rd_last_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;
  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W:0]   mem_d [FIFO_DEPTH];

  logic              push, pop, cmd_fire, can_issue;
  logic [SUM_W-1:0]  committed;
  logic [DATA_W:0]   head;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    m_valid   = (count_q != '0);
    m_data    = m_valid ? head[DATA_W-1:0] : '0;
    m_last    = m_valid & head[DATA_W];
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    push      = inflight_q;
    pop       = m_valid && m_ready;
    cmd_fire  = cmd_valid && cmd_ready;
    // Credit counts buffered words plus both read pipeline stages, so a push never finds the FIFO full.
    committed = SUM_W'(count_q) + SUM_W'(inflight_q) + SUM_W'(ram_rd_q);
    can_issue = (remaining_q != '0) && (committed < SUM_W'(FIFO_DEPTH));

    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    ram_rd_d        = 1'b0;
    ram_rd_add_d    = ram_rd_add_q;
    rd_last_d       = 1'b0;
    inflight_d      = ram_rd_q;
    inflight_last_d = rd_last_q;
    done_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            ram_rd_d     = 1'b1;
            ram_rd_add_d = cmd_addr;
            cur_addr_d   = cmd_addr + ADDR_W'(1);
            remaining_d  = cmd_len - LEN_W'(1);
            rd_last_d    = (cmd_len == LEN_W'(1));
            state_d      = (cmd_len == LEN_W'(1)) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (can_issue) begin
          ram_rd_d     = 1'b1;
          ram_rd_add_d = cur_addr_q;
          cur_addr_d   = cur_addr_q + ADDR_W'(1);
          remaining_d  = remaining_q - LEN_W'(1);
          rd_last_d    = (remaining_q == LEN_W'(1));
          if (remaining_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head[DATA_W]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {inflight_last_q, ram_rdata};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      ram_rd_q        <= 1'b0;
      ram_rd_add_q    <= '0;
      rd_last_q       <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      ram_rd_q        <= ram_rd_d;
      ram_rd_add_q    <= ram_rd_add_d;
      rd_last_q       <= rd_last_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      done_q          <= done_d;
    end
  end

  // Storage needs no reset: contents are only visible through m_valid gating.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ram_rd     = ram_rd_q;
  assign ram_rd_add = ram_rd_add_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// =============================================================================
// tb_ram_stream_reader : directed self-checking bench for ram_stream_reader
// Revision: 1.0
// =============================================================================
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_addr = '0;
  logic [12:0] cmd_len = '0;
  logic        ram_rd;
  logic [11:0] ram_rd_add;
  logic [63:0] ram_rdata = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [63:0] ram [4096];
  logic [64:0] beats [$];
  logic [11:0] rdaddrs [$];
  int          done_cnt = 0;
  int          valid_cycles = 0;

  ram_stream_reader #(.ADDR_W(12), .DATA_W(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_rd(ram_rd), .ram_rd_add(ram_rd_add),
    .ram_rdata(ram_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= ram_rd ? ram[ram_rd_add] : 64'h0;

  // Observe handshakes mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (m_valid && m_ready) beats.push_back({m_last, m_data});
    if (ram_rd) rdaddrs.push_back(ram_rd_add);
    if (done) done_cnt++;
    if (m_valid) valid_cycles++;
  end

  function automatic logic [63:0] pat(input logic [11:0] a);
    return {16'hC0DE, 4'h0, a, 20'h0, ~a};
  endfunction

  task automatic clear_obs();
    beats.delete();
    rdaddrs.delete();
    done_cnt = 0;
    valid_cycles = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [11:0] a, input logic [12:0] l);
    int n;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick(1);
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL cmd_accept: cmd_ready stayed %b, required 1 within 200 cycles", cmd_ready);
    end
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n;
    int start;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < max) begin
      tick(1);
      n++;
    end
    tests++;
    if (done_cnt == start) begin
      fails++;
      $display("FAIL done_timeout: no done pulse, required one within %0d cycles", max);
    end
    tick(2);
  endtask

  task automatic check_burst(input string name, input logic [11:0] a, input int len);
    logic [64:0] exp;
    tests++;
    if (beats.size() != len) begin
      fails++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, beats.size(), len);
    end else begin
      for (int i = 0; i < len; i++) begin
        exp = {(i == len - 1), pat(a + 12'(i))};
        tests++;
        if (beats[i] !== exp) begin
          fails++;
          $display("FAIL %s_beat%0d: got %h, required %h", name, i, beats[i], exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    tick(1);
    tests++;
    if ({cmd_ready, ram_rd, ram_rd_add, m_valid, m_last, busy, done} !== {1'b1, 1'b0, 12'h0, 4'b0000}) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b rd=%b add=%h v=%b l=%b busy=%b done=%b, required 1 0 000 0 0 0 0",
               cmd_ready, ram_rd, ram_rd_add, m_valid, m_last, busy, done);
    end
    tests++;
    if (m_data !== 64'h0) begin
      fails++;
      $display("FAIL reset_mdata: got %h, required 0", m_data);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    logic [63:0] a [4];
    a[0] = 64'hA0A0_0000_1111_0000;
    a[1] = 64'hA1A1_0000_2222_0001;
    a[2] = 64'hA2A2_0000_3333_0002;
    a[3] = 64'hA3A3_0000_4444_0003;
    for (int i = 0; i < 4; i++) ram[12'h010 + 12'(i)] = a[i];
    clear_obs();
    m_ready   = 1'b1;
    cmd_valid = 1'b1;
    cmd_addr  = 12'h010;
    cmd_len   = 13'd4;
    tick(1);
    cmd_valid = 1'b0;
    tests++;
    if ({busy, cmd_ready, ram_rd, ram_rd_add, m_valid} !== {3'b101, 12'h010, 1'b0}) begin
      fails++;
      $display("FAIL basic_E0: got busy=%b rdy=%b rd=%b add=%h v=%b, required 1 0 1 010 0",
               busy, cmd_ready, ram_rd, ram_rd_add, m_valid);
    end
    tick(1);
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_E1_valid: got %b, required 0", m_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      tests++;
      if ({m_valid, m_last, m_data} !== {1'b1, (i == 3), a[i]}) begin
        fails++;
        $display("FAIL basic_beat%0d: got v=%b l=%b d=%h, required v=1 l=%b d=%h",
                 i, m_valid, m_last, m_data, (i == 3), a[i]);
      end
    end
    tick(1);
    tests++;
    if ({m_valid, done, cmd_ready, busy} !== 4'b0110) begin
      fails++;
      $display("FAIL basic_done: got v=%b done=%b rdy=%b busy=%b, required 0 1 1 0",
               m_valid, done, cmd_ready, busy);
    end
    tick(1);
    tests++;
    if (done !== 1'b0 || beats.size() != 4) begin
      fails++;
      $display("FAIL basic_after: got done=%b beats=%0d, required done=0 beats=4", done, beats.size());
    end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_add [4];
    exp_add[0] = 12'hFFE; exp_add[1] = 12'hFFF; exp_add[2] = 12'h000; exp_add[3] = 12'h001;
    clear_obs();
    m_ready = 1'b1;
    send_cmd(12'hFFE, 13'd4);
    wait_done(100);
    tests++;
    if (rdaddrs.size() != 4) begin
      fails++;
      $display("FAIL wrap_reads: got %0d reads, required 4", rdaddrs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (rdaddrs[i] !== exp_add[i]) begin
          fails++;
          $display("FAIL wrap_addr%0d: got %h, required %h", i, rdaddrs[i], exp_add[i]);
        end
      end
    end
    check_burst("wrap", 12'hFFE, 4);
  endtask

  task automatic test_backpressure();
    clear_obs();
    m_ready = 1'b0;
    send_cmd(12'h200, 13'd8);
    tick(11);
    tests++;
    if (rdaddrs.size() != 4 || ram_rd !== 1'b0) begin
      fails++;
      $display("FAIL bp_reads: got %0d reads rd=%b, required 4 reads rd=0", rdaddrs.size(), ram_rd);
    end
    tests++;
    if ({m_valid, m_last, m_data} !== {2'b10, pat(12'h200)}) begin
      fails++;
      $display("FAIL bp_head: got v=%b l=%b d=%h, required v=1 l=0 d=%h", m_valid, m_last, m_data, pat(12'h200));
    end
    m_ready = 1'b1;
    wait_done(200);
    tests++;
    if (rdaddrs.size() != 8) begin
      fails++;
      $display("FAIL bp_total_reads: got %0d, required 8", rdaddrs.size());
    end
    check_burst("bp", 12'h200, 8);
  endtask

  task automatic test_len_zero();
    clear_obs();
    m_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_addr  = 12'h050;
    cmd_len   = 13'd0;
    tick(1);
    cmd_valid = 1'b0;
    tests++;
    if ({done, cmd_ready, busy} !== 3'b110) begin
      fails++;
      $display("FAIL len0_done: got done=%b rdy=%b busy=%b, required 1 1 0", done, cmd_ready, busy);
    end
    tick(5);
    tests++;
    if (rdaddrs.size() != 0 || valid_cycles != 0 || done_cnt != 1) begin
      fails++;
      $display("FAIL len0_quiet: got reads=%0d valid_cycles=%0d dones=%0d, required 0 0 1",
               rdaddrs.size(), valid_cycles, done_cnt);
    end
  endtask

  task automatic test_reset_midburst();
    int n;
    clear_obs();
    m_ready = 1'b1;
    send_cmd(12'h300, 13'd16);
    n = 0;
    while (beats.size() < 3 && n < 50) begin
      tick(1);
      n++;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cmd_ready, ram_rd, ram_rd_add, m_valid, m_last, busy, done} !== {1'b1, 1'b0, 12'h0, 4'b0000}
        || m_data !== 64'h0) begin
      fails++;
      $display("FAIL midrst_outputs: got rdy=%b rd=%b add=%h v=%b l=%b busy=%b done=%b d=%h, required reset values",
               cmd_ready, ram_rd, ram_rd_add, m_valid, m_last, busy, done, m_data);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear_obs();
    send_cmd(12'h100, 13'd2);
    wait_done(100);
    check_burst("midrst", 12'h100, 2);
  endtask

  task automatic test_back_to_back();
    int n;
    logic held_ok;
    clear_obs();
    m_ready = 1'b1;
    send_cmd(12'h400, 13'd3);
    cmd_valid = 1'b1;
    cmd_addr  = 12'h500;
    cmd_len   = 13'd2;
    held_ok = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (cmd_ready !== 1'b0) held_ok = 1'b0;
      tick(1);
      n++;
    end
    tests++;
    if (!held_ok || done !== 1'b1 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_hold: held_ok=%b done=%b rdy=%b, required 1 1 1", held_ok, done, cmd_ready);
    end
    tick(1);
    cmd_valid = 1'b0;
    wait_done(100);
    tests++;
    if (beats.size() != 5) begin
      fails++;
      $display("FAIL b2b_count: got %0d beats, required 5", beats.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        logic [64:0] exp;
        exp = (i < 3) ? {(i == 2), pat(12'h400 + 12'(i))} : {(i == 4), pat(12'h500 + 12'(i - 3))};
        tests++;
        if (beats[i] !== exp) begin
          fails++;
          $display("FAIL b2b_beat%0d: got %h, required %h", i, beats[i], exp);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = pat(12'(i));
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_reset_midburst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
